// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue: PC step, default widths
// and the layout of one queued prediction.
package branch_resolve_queue_pkg;

    localparam int PC_W_DEF = 32;
    localparam int PC_STEP  = 4;

    // One queue entry at the default PC width; wider/narrower builds use the
    // same field order {pc, pred_taken, pred_target} packed into a flat vector.
    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic                pred_taken;
        logic [PC_W_DEF-1:0] pred_target;
    } brq_entry_t;

    function automatic int entry_w(input int pc_w);
        return 2 * pc_w + 1;
    endfunction

endpackage

// File: rtl/branch_queue_fifo.sv
// Generic DEPTH x WIDTH circular FIFO with push, pop and a synchronous clear
// that takes priority over both.
module branch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_pop, do_push;

    assign do_pop  = pop_i && (cnt_q != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches resolved by EX: flags mispredicts,
// drives redirect/flush, predictor update pulses and statistics.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [PC_W-1:0]        push_pc,
    input  logic                   push_pred_taken,
    input  logic [PC_W-1:0]        push_pred_target,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic [PC_W-1:0]        res_target,
    output logic                   upd_valid,
    output logic                   upd_taken,
    output logic                   mispredict,
    output logic [PC_W-1:0]        redirect_pc,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_overflow,
    output logic                   err_underflow,
    output logic [CNT_W-1:0]       num_branches,
    output logic [CNT_W-1:0]       num_mispredicts
);

    localparam int EW = entry_w(PC_W);

    logic [EW-1:0]   push_entry, head;
    logic [PC_W-1:0] h_pc, h_target;
    logic            h_pred_taken;
    logic            pop, mis, flush, fifo_push;

    logic            upd_valid_q, upd_valid_d;
    logic            upd_taken_q, upd_taken_d;
    logic            mis_q, mis_d;
    logic [PC_W-1:0] redirect_q, redirect_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_unf_q, err_unf_d;
    logic [CNT_W-1:0] nb_q, nb_d;
    logic [CNT_W-1:0] nm_q, nm_d;

    assign push_entry   = {push_pc, push_pred_taken, push_pred_target};
    assign h_pc         = head[EW-1 -: PC_W];
    assign h_pred_taken = head[PC_W];
    assign h_target     = head[PC_W-1:0];

    assign pop   = res_valid && !empty;
    assign mis   = (h_pred_taken != res_taken) || (res_taken && (h_target != res_target));
    assign flush = pop && mis;
    // Pushes arriving alongside a flush are wrong-path and simply vanish.
    assign fifo_push = push_valid && !flush;

    branch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .clear_i (flush),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        upd_valid_d = pop;
        upd_taken_d = pop && res_taken;
        mis_d       = flush;
        redirect_d  = redirect_q;
        err_ovf_d   = err_ovf_q;
        err_unf_d   = err_unf_q;
        nb_d        = nb_q;
        nm_d        = nm_q;
        if (pop) begin
            redirect_d = res_taken ? res_target : h_pc + PC_W'(PC_STEP);
            nb_d       = nb_q + CNT_W'(1);
            if (mis) nm_d = nm_q + CNT_W'(1);
        end
        if (fifo_push && full && !pop) err_ovf_d = 1'b1;
        if (res_valid && empty)        err_unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            mis_q       <= 1'b0;
            redirect_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            nb_q        <= '0;
            nm_q        <= '0;
        end else begin
            upd_valid_q <= upd_valid_d;
            upd_taken_q <= upd_taken_d;
            mis_q       <= mis_d;
            redirect_q  <= redirect_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            nb_q        <= nb_d;
            nm_q        <= nm_d;
        end
    end

    assign upd_valid       = upd_valid_q;
    assign upd_taken       = upd_taken_q;
    assign mispredict      = mis_q;
    assign redirect_pc     = redirect_q;
    assign err_overflow    = err_ovf_q;
    assign err_underflow   = err_unf_q;
    assign num_branches    = nb_q;
    assign num_mispredicts = nm_q;

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Resolution-side counterpart to the 2-bit branch predictor.
- IF pushes each predicted branch (PC, predicted direction, predicted target) into an in-order queue.
- EX resolves the oldest entry with the real outcome. The block flags mispredictions, drives the redirect PC and flush, and emits the registered is_branch/is_taken update pulse to the predictor.
- It also keeps branch and mispredict statistics counters.

Parameters:
DEPTH, 4, queue entries; power of 2, at least 2
PC_W, 32, PC/target width
CNT_W, 32, statistics counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
push_valid  input  1  IF: predicted branch enters queue
push_pc  input  PC_W  IF: branch PC
push_pred_taken  input  1  IF: predictor output for this branch
push_pred_target  input  PC_W  IF: predicted target (ignored when not taken)
res_valid  input  1  EX: oldest queued branch resolves this cycle
res_taken  input  1  EX: actual direction
res_target  input  PC_W  EX: actual taken target
upd_valid  output  1  to predictor is_branch (registered pulse)
upd_taken  output  1  to predictor is_taken
mispredict  output  1  registered flush pulse
redirect_pc  output  PC_W  correct next PC, valid with mispredict
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  $clog2(DEPTH)+1  occupancy
err_overflow  output  1  sticky: push while full without pop
err_underflow  output  1  sticky: res_valid while empty
num_branches  output  CNT_W  resolved branches, wraps
num_mispredicts  output  CNT_W  mispredicts, wraps

Behaviour:
- Reset (async, any time, including mid-flush): pointers, count, all registered outputs, error flags and counters go to 0; empty=1; queue contents are don't-care.
- Storage: circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH; count is a separate register; full/empty are combinational from count.
- Resolve (res_valid && !empty), evaluated against the head entry H:
  - Mispredict condition: H.pred_taken != res_taken, OR (res_taken && H.pred_target != res_target).
  - Correct path: redirect_pc_next = res_taken ? res_target : H.pc + 4 (the +4 is modulo 2^PC_W).
  - Head is popped.
  - num_branches increments; num_mispredicts increments on a mispredict.
- Outputs are registered, one-cycle latency: upd_valid, upd_taken, mispredict and redirect_pc appear the cycle after res_valid.
  - upd_valid and mispredict are single-cycle pulses.
  - redirect_pc holds its last value otherwise.
- Flush on mispredict (same edge as the resolve): every younger entry is on the wrong path. Queue is cleared (rd=wr=0, count=0), and any push in the same cycle is discarded, not counted as overflow.
- Push (push_valid, no flush):
  - If count < DEPTH, or a non-mispredicting pop occurs in the same cycle: write at wr, advance wr.
  - Simultaneous push and pop leaves count unchanged.
  - Push while full with no pop: dropped, err_overflow set.
- res_valid while empty: ignored (no pop, no pulse, no counter change); err_underflow set.
- Error flags clear only on reset.
- No back-pressure; IF must stall on full.

Decomposition:
- Shared package holds:
  - PC_W default
  - localparam PC_STEP = 4
  - the queue entry struct/field layout {pc, pred_taken, pred_target}
- One sub-module is natural: branch_queue_fifo, a generic DEPTH x width circular FIFO with push, pop and clear (synchronous flush), full/empty/count.
- The mispredict compare, redirect mux and counters stay in the top level.

Test Plan:
- Correct-taken path:
  - Stimulus: reset, then push {pc=0x100, pred_taken=1, target=0x200}; next cycle res_valid with taken=1, target=0x200.
  - Required: one cycle later upd_valid=1, upd_taken=1, mispredict=0; num_branches=1; empty=1.
- Direction mispredict with flush:
  - Stimulus: push 0x100 (pred taken, 0x200), 0x104, 0x108; resolve the head with taken=0.
  - Required: mispredict=1, redirect_pc=0x104; count=0 the cycle after; a push asserted in the resolve cycle is dropped; num_mispredicts=1.
- Target mispredict:
  - Stimulus: head pred_taken=1, target=0x200; resolve taken=1, target=0x240.
  - Required: mispredict=1, redirect_pc=0x240, upd_taken=1.
- Full/wrap:
  - Stimulus: push 4 entries (full=1); push a 5th alone; then push and correct-resolve simultaneously for 10 cycles.
  - Required: 5th push sets err_overflow; count stays at 4 during the paired cycles; pointers wrap; the resolve order matches the push order.
- Underflow:
  - Stimulus: res_valid on an empty queue.
  - Required: no upd_valid pulse, counters unchanged, err_underflow=1 until reset.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges with 3 entries queued and a mispredict pulse pending.
  - Required: all outputs 0 immediately, empty=1 before the next edge.
